pulse_seq_fsm: RTL and testbench

- Parametrised pulse-train sequence detector; generalises the fixed 4-state A-toggle FSM (Idle/Start/Stop/Clear).
- Counts PULSES complete high pulses on serial input A, with a glitch filter and an optional inter-edge timeout.
- F flags that the final pulse is in progress; G flags that the sequence completed.
- Sits in control logic downstream of a slow external strobe line.

---
 rtl/pulse_seq_pkg.sv | 27 ++
 rtl/pulse_seq_fsm_if.sv | 27 ++
 rtl/pulse_seq_filter.sv | 46 ++++
 rtl/pulse_seq_fsm.sv | 133 +++++++++++++
 tb/tb_pulse_seq_fsm.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and width helpers for the pulse-train sequence detector.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Width of the rise counter: must hold 0..PULSES.
  function automatic int cw_width(input int pulses);
    return $clog2(pulses + 1);
  endfunction

  // Width of the glitch-filter hold counter: must hold 0..MIN_HOLD-1.
  function automatic int hold_width(input int min_hold);
    return $clog2(min_hold + 1);
  endfunction

  // Width of the inter-edge timer; at least one bit even when timeout is off.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_seq_fsm_if.sv
// Signal bundle between the strobe source (master) and the detector (slave).
interface pulse_seq_fsm_if
  import pulse_seq_pkg::*;
#(
  parameter int PULSES = 2
);

  localparam int CW = cw_width(PULSES);

  logic          A;
  logic          F;
  logic          G;
  logic          Err;
  logic          Busy;
  logic [CW-1:0] Count;

  modport master (
    output A,
    input  F, G, Err, Busy, Count
  );

  modport slave (
    input  A,
    output F, G, Err, Busy, Count
  );

endinterface

// File: rtl/pulse_seq_filter.sv
// Glitch filter: A must differ from the accepted level for MIN_HOLD
// consecutive posedges before the new level is accepted.
module pulse_seq_filter
  import pulse_seq_pkg::*;
#(
  parameter int MIN_HOLD = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_a,
  output logic o_filt,
  output logic o_rise_evt,
  output logic o_fall_evt
);

  localparam int HW = hold_width(MIN_HOLD);
  localparam logic [HW-1:0] LP_HOLD_LAST = HW'(MIN_HOLD - 1);

  logic          r_filt;
  logic [HW-1:0] r_hold;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = (i_a != r_filt);
  assign w_accept = w_diff && (r_hold == LP_HOLD_LAST);

  // Track the accepted level and how long A has disagreed with it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_filt <= 1'b0;
      r_hold <= '0;
    end else if (!w_diff) begin
      r_hold <= '0;
    end else if (w_accept) begin
      r_filt <= i_a;
      r_hold <= '0;
    end else begin
      r_hold <= r_hold + HW'(1);
    end
  end

  assign o_filt     = r_filt;
  assign o_rise_evt = w_accept &  i_a;
  assign o_fall_evt = w_accept & ~i_a;

endmodule

// File: rtl/pulse_seq_fsm.sv
// Counts PULSES filtered high pulses on A. F marks the final pulse in
// progress, G marks a completed sequence, Err flags an inter-edge timeout.
module pulse_seq_fsm
  import pulse_seq_pkg::*;
#(
  parameter int PULSES   = 2,
  parameter int MIN_HOLD = 1,
  parameter int TIMEOUT  = 0
) (
  input  logic            Clock,
  input  logic            Reset,
  pulse_seq_fsm_if.slave  bus
);

  localparam int CW = cw_width(PULSES);
  localparam int TW = timer_width(TIMEOUT);
  localparam logic [CW-1:0] LP_PULSES = CW'(PULSES);
  localparam logic [TW-1:0] LP_TLAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        r_state,  w_state_nxt;
  logic [CW-1:0] r_count,  w_count_nxt;
  logic [CW-1:0] w_count_inc;
  logic          r_f,      w_f_nxt;
  logic          r_g,      w_g_nxt;
  logic          r_err,    w_err_nxt;
  logic [TW-1:0] r_timer,  w_timer_nxt;
  logic          w_rise_evt;
  logic          w_fall_evt;
  logic          w_accept;
  logic          w_expire;

  pulse_seq_filter #(
    .MIN_HOLD (MIN_HOLD)
  ) u_filter (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_a        (bus.A),
    .o_filt     (),
    .o_rise_evt (w_rise_evt),
    .o_fall_evt (w_fall_evt)
  );

  assign w_accept    = w_rise_evt | w_fall_evt;
  assign w_count_inc = r_count + CW'(1);
  // An accepted edge in the expiry cycle takes priority over the abort.
  assign w_expire    = (TIMEOUT > 0) && (r_state != IDLE) && !w_accept &&
                       (r_timer == LP_TLAST);

  // State, counter, flag and timer registers; reset wins over everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_f     <= 1'b0;
      r_g     <= 1'b0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_f     <= w_f_nxt;
      r_g     <= w_g_nxt;
      r_err   <= w_err_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state, counter and flag logic driven by filtered edge events.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_f_nxt     = r_f;
    w_g_nxt     = r_g;
    w_err_nxt   = 1'b0;
    w_timer_nxt = '0;

    if (w_expire) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
      w_f_nxt     = 1'b0;
      w_err_nxt   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise_evt) begin
            w_state_nxt = HIGH;
            w_count_nxt = CW'(1);
            w_g_nxt     = 1'b0;
            w_f_nxt     = (LP_PULSES == CW'(1));
          end
        end
        HIGH: begin
          if (w_fall_evt) begin
            if (r_count == LP_PULSES) begin
              w_state_nxt = IDLE;
              w_count_nxt = '0;
              w_f_nxt     = 1'b0;
              w_g_nxt     = 1'b1;
            end else begin
              w_state_nxt = LOW;
            end
          end
        end
        LOW: begin
          if (w_rise_evt) begin
            w_state_nxt = HIGH;
            w_count_nxt = w_count_inc;
            w_f_nxt     = (w_count_inc == LP_PULSES);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_f_nxt     = 1'b0;
        end
      endcase
    end

    // Timer restarts on every accepted edge and whenever we land in IDLE.
    if ((TIMEOUT == 0) || (w_state_nxt == IDLE) || w_accept) begin
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = r_timer + TW'(1);
    end
  end

  assign bus.F     = r_f;
  assign bus.G     = r_g;
  assign bus.Err   = r_err;
  assign bus.Count = r_count;
  assign bus.Busy  = (r_state != IDLE);

endmodule

// File: tb/tb_pulse_seq_fsm.sv
// Directed bench for pulse_seq_fsm across four parameter sets.
module tb_pulse_seq_fsm;
  import pulse_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  // u0: legacy 2-pulse, u1: MIN_HOLD=3, u2: 3 pulses, u3: TIMEOUT=10
  pulse_seq_fsm_if #(.PULSES(2)) if0 ();
  pulse_seq_fsm_if #(.PULSES(2)) if1 ();
  pulse_seq_fsm_if #(.PULSES(3)) if2 ();
  pulse_seq_fsm_if #(.PULSES(2)) if3 ();

  pulse_seq_fsm #(.PULSES(2), .MIN_HOLD(1), .TIMEOUT(0))  u0 (.Clock(clk), .Reset(rst), .bus(if0.slave));
  pulse_seq_fsm #(.PULSES(2), .MIN_HOLD(3), .TIMEOUT(0))  u1 (.Clock(clk), .Reset(rst), .bus(if1.slave));
  pulse_seq_fsm #(.PULSES(3), .MIN_HOLD(1), .TIMEOUT(0))  u2 (.Clock(clk), .Reset(rst), .bus(if2.slave));
  pulse_seq_fsm #(.PULSES(2), .MIN_HOLD(1), .TIMEOUT(10)) u3 (.Clock(clk), .Reset(rst), .bus(if3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    if0.A  = 1'b0;
    if1.A  = 1'b0;
    if2.A  = 1'b0;
    if3.A  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy0",  if0.Busy,  0);
    chk("rst_count0", if0.Count, 0);
    chk("rst_f0",     if0.F,     0);
    chk("rst_g0",     if0.G,     0);
    chk("rst_err3",   if3.Err,   0);
    chk("rst_busy3",  if3.Busy,  0);
    rst = 1'b0;

    // u0: A = 0,1,1,0,0,1,1,0 on cycles 0..7
    if0.A = 1'b0; tick();                       // cycle 0
    chk("u0_c0_busy", if0.Busy, 0);
    if0.A = 1'b1; tick();                       // cycle 1
    chk("u0_c1_busy",  if0.Busy,  1);
    chk("u0_c1_count", if0.Count, 1);
    chk("u0_c1_f",     if0.F,     0);
    if0.A = 1'b1; tick();                       // cycle 2
    if0.A = 1'b0; tick();                       // cycle 3
    chk("u0_c3_busy",  if0.Busy,  1);
    chk("u0_c3_count", if0.Count, 1);
    if0.A = 1'b0; tick();                       // cycle 4
    chk("u0_c4_f",     if0.F,     0);
    if0.A = 1'b1; tick();                       // cycle 5
    chk("u0_c5_count", if0.Count, 2);
    chk("u0_c5_f",     if0.F,     1);
    if0.A = 1'b1; tick();                       // cycle 6
    chk("u0_c6_f",     if0.F,     1);
    chk("u0_c6_g",     if0.G,     0);
    if0.A = 1'b0; tick();                       // cycle 7
    chk("u0_c7_f",     if0.F,     0);
    chk("u0_c7_g",     if0.G,     1);
    chk("u0_c7_count", if0.Count, 0);
    chk("u0_c7_busy",  if0.Busy,  0);

    // u1: MIN_HOLD=3, 2-cycle glitch is rejected, 3-cycle level accepted
    if1.A = 1'b1; tick();
    if1.A = 1'b1; tick();
    chk("u1_glitch_busy", if1.Busy, 0);
    if1.A = 1'b0; tick();
    chk("u1_after_glitch_busy", if1.Busy, 0);
    if1.A = 1'b1; tick();
    if1.A = 1'b1; tick();
    chk("u1_hold2_busy", if1.Busy, 0);
    if1.A = 1'b1; tick();
    chk("u1_hold3_busy",  if1.Busy,  1);
    chk("u1_hold3_count", if1.Count, 1);

    // u2: 3-pulse train, F only on the 3rd pulse, G sticky until next rise
    if2.A = 1'b1; tick();
    chk("u2_r1_count", if2.Count, 1);
    chk("u2_r1_f",     if2.F,     0);
    if2.A = 1'b0; tick();
    if2.A = 1'b1; tick();
    chk("u2_r2_count", if2.Count, 2);
    chk("u2_r2_f",     if2.F,     0);
    if2.A = 1'b0; tick();
    chk("u2_f2_busy",  if2.Busy,  1);
    if2.A = 1'b1; tick();
    chk("u2_r3_count", if2.Count, 3);
    chk("u2_r3_f",     if2.F,     1);
    if2.A = 1'b0; tick();
    chk("u2_f3_f",     if2.F,     0);
    chk("u2_f3_g",     if2.G,     1);
    chk("u2_f3_count", if2.Count, 0);
    chk("u2_f3_busy",  if2.Busy,  0);
    if2.A = 1'b0; tick();
    chk("u2_idle_g",   if2.G,     1);
    if2.A = 1'b1; tick();
    chk("u2_new_g",     if2.G,     0);
    chk("u2_new_count", if2.Count, 1);
    chk("u2_new_busy",  if2.Busy,  1);

    // u3: timeout abort 10 cycles after the rise
    if3.A = 1'b1; tick();
    chk("u3_rise_busy", if3.Busy, 1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("u3_wait_err", if3.Err, 0);
    end
    chk("u3_c9_busy", if3.Busy, 1);
    tick();
    chk("u3_abort_err",   if3.Err,   1);
    chk("u3_abort_busy",  if3.Busy,  0);
    chk("u3_abort_f",     if3.F,     0);
    chk("u3_abort_count", if3.Count, 0);
    tick();
    chk("u3_err_once", if3.Err,  0);
    chk("u3_stay_idle", if3.Busy, 0);
    tick();
    if3.A = 1'b0; tick();
    chk("u3_fall_busy",  if3.Busy,  0);
    chk("u3_fall_count", if3.Count, 0);
    chk("u3_fall_err",   if3.Err,   0);
    if3.A = 1'b1; tick();
    chk("u3_new_busy",  if3.Busy,  1);
    chk("u3_new_count", if3.Count, 1);

    // u3: fall accepted in the expiry cycle wins over the abort
    for (int i = 1; i <= 9; i++) begin
      tick();
    end
    chk("u3_pre_busy", if3.Busy, 1);
    if3.A = 1'b0; tick();
    chk("u3_race_err",   if3.Err,   0);
    chk("u3_race_busy",  if3.Busy,  1);
    chk("u3_race_count", if3.Count, 1);
    tick();
    chk("u3_race_err2",  if3.Err,   0);

    // Reset mid-sequence (u3 in LOW, u0 idle with G=1), A0 held high
    if0.A = 1'b1;
    rst   = 1'b1;
    tick();
    chk("mrst_u3_busy",  if3.Busy,  0);
    chk("mrst_u3_count", if3.Count, 0);
    chk("mrst_u0_g",     if0.G,     0);
    chk("mrst_u0_busy",  if0.Busy,  0);
    chk("mrst_u0_count", if0.Count, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_u0_busy",  if0.Busy,  1);
    chk("post_rst_u0_count", if0.Count, 1);
    chk("post_rst_u3_busy",  if3.Busy,  0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
